// File: rtl/bitpacked_id_unpacker.sv
// Bit-packed dictionary ID unpacker: LSB-first byte stream in,
// beats of NUM_ELEMENTS zero-extended IDs with per-element keep/last out.
module bitpacked_id_unpacker #(
    parameter int IN_BYTES     = 64,
    parameter int NUM_ELEMENTS = 16,
    parameter int ID_BITS      = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [4:0]                      cfg_width,
    input  logic [31:0]                     cfg_count,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    input  logic [IN_BYTES*8-1:0]           in_data,
    input  logic                            in_last,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [NUM_ELEMENTS*ID_BITS-1:0] out_data,
    output logic [NUM_ELEMENTS-1:0]         out_keep,
    output logic                            out_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            status_short
);
    localparam int IN_W     = IN_BYTES * 8;
    localparam int BUF_BITS = 2 * IN_W;
    localparam int FW       = $clog2(BUF_BITS + 1);
    localparam int NW       = $clog2(NUM_ELEMENTS + 1);
    localparam int OUT_W    = NUM_ELEMENTS * ID_BITS;

    if (OUT_W > IN_W) begin : g_bad_params
        $error("NUM_ELEMENTS*ID_BITS exceeds IN_BYTES*8");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [4:0]            w_q;
    logic [31:0]           r_q;
    logic [FW-1:0]         f_q, f_d;
    logic [BUF_BITS-1:0]   buf_q, buf_d, app_c;
    logic                  in_done_q;
    logic [OUT_W-1:0]      out_data_q, data_c;
    logic [NUM_ELEMENTS-1:0] out_keep_q, keep_c;
    logic                  out_last_q, out_valid_q, status_short_q;

    logic                  cfg_hs, in_hs, acc, out_free;
    logic                  fits, emit, consume, short_c, last_c;
    logic [NW-1:0]         n_c;
    logic [FW-1:0]         need_c;
    logic [ID_BITS-1:0]    w_mask;

    assign cfg_ready    = (state_q == IDLE);
    assign cfg_hs       = cfg_valid && cfg_ready;
    assign in_hs        = in_valid && in_ready;
    assign acc          = in_hs && (state_q == RUN);
    assign out_free     = !out_valid_q || out_ready;
    assign out_data     = out_data_q;
    assign out_keep     = out_keep_q;
    assign out_last     = out_last_q;
    assign out_valid    = out_valid_q;
    assign status_short = status_short_q;

    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            RUN:     in_ready = !in_done_q && (f_q <= FW'(IN_W));
            DRAIN:   in_ready = !in_done_q;
            default: in_ready = 1'b0;
        endcase
    end

    // A beat is short when input is exhausted before its IDs, or when
    // no complete ID would remain for a further beat.
    always_comb begin
        n_c = (r_q < 32'(NUM_ELEMENTS)) ? NW'(r_q) : NW'(NUM_ELEMENTS);
        need_c  = FW'(n_c) * FW'(w_q);
        fits    = (f_q >= need_c);
        emit    = (state_q == RUN) && out_free && (fits || in_done_q);
        consume = emit && fits;
        short_c = emit && in_done_q && (!fits ||
                  ((r_q > 32'(n_c)) && (f_q - need_c < FW'(w_q))));
        last_c  = (r_q <= 32'(NUM_ELEMENTS)) || short_c;
    end

    always_comb begin
        w_mask = ~({ID_BITS{1'b1}} << w_q);
        keep_c = '0;
        data_c = '0;
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            keep_c[i] = (NW'(i) < n_c) &&
                        (FW'(i + 1) * FW'(w_q) <= f_q);
            if (keep_c[i]) begin
                data_c[i*ID_BITS +: ID_BITS] =
                    ID_BITS'(buf_q >> (i * int'(w_q))) & w_mask;
            end
        end
    end

    always_comb begin
        app_c = buf_q;
        if (acc) begin
            app_c = buf_q | (BUF_BITS'(in_data) << f_q);
        end
        buf_d = consume ? (app_c >> need_c) : app_c;
        f_d   = f_q + (acc ? FW'(IN_W) : '0) - (consume ? need_c : '0);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cfg_hs) begin
                    state_d = (cfg_count == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (emit && last_c) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (in_done_q && out_free) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q            <= '0;
            r_q            <= '0;
            f_q            <= '0;
            buf_q          <= '0;
            in_done_q      <= 1'b0;
            out_data_q     <= '0;
            out_keep_q     <= '0;
            out_last_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            status_short_q <= 1'b0;
        end else if (cfg_hs) begin
            w_q            <= cfg_width;
            r_q            <= cfg_count;
            f_q            <= '0;
            buf_q          <= '0;
            in_done_q      <= 1'b0;
            status_short_q <= 1'b0;
            if (cfg_count == '0) begin
                out_data_q  <= '0;
                out_keep_q  <= '0;
                out_last_q  <= 1'b1;
                out_valid_q <= 1'b1;
            end
        end else begin
            if (in_hs && in_last) begin
                in_done_q <= 1'b1;
            end
            if (state_q == RUN) begin
                buf_q <= buf_d;
                f_q   <= f_d;
            end
            if (emit) begin
                out_data_q  <= data_c;
                out_keep_q  <= keep_c;
                out_last_q  <= last_c;
                out_valid_q <= 1'b1;
                r_q <= short_c ? '0 : r_q - 32'(n_c);
                if (short_c) begin
                    status_short_q <= 1'b1;
                end
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    a_cfg_width: assert property (@(posedge clk) disable iff (rst)
        cfg_hs |-> (cfg_width != 5'd0 && 32'(cfg_width) <= ID_BITS))
        else $fatal(1, "cfg_width out of range");

endmodule

// File: tb/tb_bitpacked_id_unpacker.sv
// Bench for bitpacked_id_unpacker: table of streams, model-built
// scoreboard of expected beats, plus a reset-mid-stream sequence.
module tb_bitpacked_id_unpacker;
    localparam int IN_W = 512;
    localparam int NE   = 16;
    localparam int IB   = 16;
    localparam int OW   = NE * IB;
    localparam int MAXB = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [4:0]      cfg_width;
    logic [31:0]     cfg_count;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [IN_W-1:0] in_data;
    logic            in_last;
    logic            in_valid;
    logic            in_ready;
    logic [OW-1:0]   out_data;
    logic [NE-1:0]   out_keep;
    logic            out_last;
    logic            out_valid;
    logic            out_ready;
    logic            status_short;

    bitpacked_id_unpacker dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_width    (cfg_width),
        .cfg_count    (cfg_count),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_keep     (out_keep),
        .out_last     (out_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .status_short (status_short)
    );

    always #5 clk = ~clk;

    typedef struct {
        int w;
        int cnt;
        int nb;
        int pat;
        int rdy;
        int exp_beats;
        bit exp_short;
    } vec_t;

    typedef struct {
        logic [OW-1:0] data;
        logic [NE-1:0] keep;
        logic          last;
    } beat_t;

    beat_t sb[$];
    int n_cmp = 0;
    int n_err = 0;
    int beats_seen = 0;
    int rdy_pct = 100;
    logic [MAXB*IN_W-1:0] stream;
    vec_t vecs[10];

    task automatic check(string name, logic [OW-1:0] act,
                         logic [OW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [IB-1:0] id_val(int pat, int i, int w);
        int v;
        case (pat)
            0:       v = i;
            1:       v = i % 8;
            default: v = i * 37 + 11;
        endcase
        return IB'(v & ((1 << w) - 1));
    endfunction

    function automatic beat_t mk_beat(int pat, int pos, int k, int w,
                                      bit last);
        beat_t b;
        b.data = '0;
        b.keep = '0;
        b.last = last;
        for (int j = 0; j < k; j++) begin
            b.data[j*IB +: IB] = id_val(pat, pos + j, w);
            b.keep[j] = 1'b1;
        end
        return b;
    endfunction

    // Output backpressure
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = (int'($urandom_range(0, 99)) < rdy_pct);
        end
    end

    // Output monitor: scoreboard pop and stall stability
    initial begin
        bit    stall;
        beat_t held;
        beat_t e;
        logic [OW-1:0] m;
        stall = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 0;
            end else begin
                if (stall) begin
                    check("hold_valid", OW'(out_valid), OW'(1));
                    check("hold_data", out_data, held.data);
                    check("hold_keep", OW'(out_keep), OW'(held.keep));
                end
                if (out_valid && out_ready) begin
                    beats_seen++;
                    stall = 0;
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL extra_beat: got keep %0h expected none",
                                 out_keep);
                    end else begin
                        e = sb.pop_front();
                        m = '0;
                        for (int j = 0; j < NE; j++) begin
                            if (e.keep[j]) m[j*IB +: IB] = '1;
                        end
                        check("beat_keep", OW'(out_keep), OW'(e.keep));
                        check("beat_last", OW'(out_last), OW'(e.last));
                        check("beat_data", out_data & m, e.data);
                    end
                end else if (out_valid) begin
                    stall = 1;
                    held.data = out_data;
                    held.keep = out_keep;
                    held.last = out_last;
                end else begin
                    stall = 0;
                end
            end
        end
    end

    task automatic send_cfg(int w, int cnt);
        int t;
        @(posedge clk);
        #1;
        cfg_width = 5'(w);
        cfg_count = cnt;
        cfg_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!cfg_ready && t < 200);
        check("cfg_accept", OW'(cfg_ready), OW'(1));
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic send_beat(logic [IN_W-1:0] d, bit last);
        int t;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 2000);
        check("in_accept", OW'(in_ready), OW'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic build_stream(vec_t v);
        logic [IB-1:0] idv;
        stream = '0;
        for (int i = 0; i < v.cnt; i++) begin
            if ((i + 1) * v.w <= v.nb * IN_W) begin
                idv = id_val(v.pat, i, v.w);
                for (int b = 0; b < v.w; b++) begin
                    stream[i*v.w + b] = idv[b];
                end
            end
        end
    endtask

    task automatic run_stream(vec_t v);
        int bits, r, f, pos, n, t;
        bit done;
        beat_t b;
        rdy_pct = v.rdy;
        beats_seen = 0;
        build_stream(v);
        bits = v.nb * IN_W;
        if (v.cnt == 0) begin
            sb.push_back(mk_beat(v.pat, 0, 0, v.w, 1'b1));
        end else begin
            r = v.cnt;
            f = bits;
            pos = 0;
            done = 0;
            while (!done) begin
                n = (r < NE) ? r : NE;
                if (f < n * v.w) begin
                    sb.push_back(mk_beat(v.pat, pos, f / v.w, v.w, 1'b1));
                    done = 1;
                end else begin
                    f -= n * v.w;
                    r -= n;
                    b = mk_beat(v.pat, pos, n, v.w,
                                (r == 0) || (f < v.w));
                    pos += n;
                    sb.push_back(b);
                    done = b.last;
                end
            end
        end
        send_cfg(v.w, v.cnt);
        for (int k = 0; k < v.nb; k++) begin
            send_beat(stream[k*IN_W +: IN_W], k == v.nb - 1);
        end
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(sb.size() == 0 && cfg_ready) && t < 3000);
        check("stream_done", OW'(sb.size() == 0 && cfg_ready), OW'(1));
        check("beat_count", OW'(beats_seen), OW'(v.exp_beats));
        check("status_short", OW'(status_short), OW'(v.exp_short));
        sb.delete();
    endtask

    initial begin
        rst       = 1'b1;
        cfg_width = '0;
        cfg_count = '0;
        cfg_valid = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        in_valid  = 1'b0;

        //          w   cnt  nb pat rdy beats short
        vecs[0] = '{8,   32, 1, 0, 100,  2, 0};
        vecs[1] = '{3,   20, 1, 1, 100,  2, 0};
        vecs[2] = '{16, 100, 4, 2,  50,  7, 0};
        vecs[3] = '{8,    0, 2, 0, 100,  1, 0};
        vecs[4] = '{16,  64, 1, 0, 100,  2, 1};
        vecs[5] = '{13,  50, 1, 2,  70,  3, 1};
        vecs[6] = '{7,  200, 3, 2,  60, 13, 0};
        vecs[7] = '{4,   16, 3, 2, 100,  1, 0};
        vecs[8] = '{1,   40, 1, 2, 100,  3, 0};
        vecs[9] = '{5,   33, 1, 2,  80,  3, 0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", OW'(out_valid), OW'(0));
        check("rst_in_ready", OW'(in_ready), OW'(0));
        check("rst_out_keep", OW'(out_keep), OW'(0));
        check("rst_out_data", out_data, '0);
        check("rst_short", OW'(status_short), OW'(0));
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_stream(vecs[i]);
        end

        // Reset while a beat is held stalled on the output
        begin
            vec_t a;
            int t;
            a = '{8, 64, 1, 0, 0, 0, 0};
            rdy_pct = 0;
            build_stream(a);
            send_cfg(a.w, a.cnt);
            send_beat(stream[IN_W-1:0], 1'b0);
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!out_valid && t < 50);
            check("abort_valid_seen", OW'(out_valid), OW'(1));
            #2;
            rst = 1'b1;
            #1;
            check("abort_out_valid", OW'(out_valid), OW'(0));
            check("abort_in_ready", OW'(in_ready), OW'(0));
            check("abort_cfg_ready", OW'(cfg_ready), OW'(1));
            check("abort_out_keep", OW'(out_keep), OW'(0));
            @(negedge clk);
            @(posedge clk);
            #1;
            rst = 1'b0;
            sb.delete();
            run_stream('{8, 16, 1, 0, 100, 1, 0});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
